fft_digitrev_reorder: RTL and testbench
=======================================

// Module: fft_digitrev_reorder
// PURPOSE
//  Output reorder stage directly downstream of the radix-4 fixed-point FFT core.
//  The core emits each frame of N=4**STAGE_NO bins in base-4 digit-reversed order.
//  This block buffers frames in a ping-pong RAM and replays them in natural bin order.
//  It presents an AXI-stream master with tlast on the final bin of every frame.
// PARAMETERS
//  STAGE_NO   5    radix-4 stages; N = 4**STAGE_NO words per frame (default 1024)
//  DATA_W     16   sample width; data passes through bit-exact, no arithmetic
// PORTS
//  aclk                    in   1       clock; all logic rising-edge
//  areset                  in   1       synchronous, active-high reset
//  s_axis_data_tdata       in   DATA_W  digit-reversed bin from FFT core
//  s_axis_data_tvalid      in   1       input word valid
//  s_axis_data_tready      out  1       input word accepted when tvalid&&tready
//  s_axis_data_tlast       in   1       FFT marks last word of frame
//  m_axis_data_tdata       out  DATA_W  natural-order bin
//  m_axis_data_tvalid      out  1       output word valid
//  m_axis_data_tready      in   1       downstream accepts
//  m_axis_data_tlast       out  1       high with bin N-1 of each frame
//  event_tlast_unexpected  out  1       1-cycle pulse: s tlast on word index != N-1
//  event_tlast_missing     out  1       1-cycle pulse: word N-1 accepted without tlast
// BEHAVIOUR
//  Reset: all outputs 0 except s_axis_data_tready=1 (first cycle after reset deassert);
//   both banks EMPTY, write/read counters 0, write bank=0, read bank=0.
//   Reset mid-frame discards all buffered data; no partial frame is ever emitted.
//  Storage: two banks of N x DATA_W words (bank=1 address bit), synchronous-read RAM.
//  Bank state per bank: EMPTY -> FILLING (first accepted word) -> FULL (word N-1
//   accepted) -> DRAINING (first read issued) -> EMPTY (bin N-1 handshaken out).
//  Write side: wcnt counts accepted words 0..N-1; write address = digitrev4(wcnt),
//   i.e. the STAGE_NO 2-bit digits of wcnt in reversed order.
//   s_axis_data_tready = write bank is EMPTY or FILLING.
//   Framing is count-based: bank closes at wcnt=N-1 regardless of tlast; wcnt wraps
//   to 0 and write bank toggles on that same cycle.
//   tlast with wcnt!=N-1: event_tlast_unexpected pulses next cycle, word still stored.
//   wcnt=N-1 without tlast: event_tlast_missing pulses next cycle.
//  Read side: rcnt 0..N-1 reads read bank at natural address rcnt.
//   m_axis_data_tdata = word written at wcnt=digitrev4(rcnt) (digitrev4 is involution).
//   First m_axis_data_tvalid exactly 2 cycles after the accepting edge of input word
//   N-1, when the read bank was idle (1 cycle to mark FULL, 1 cycle RAM read).
//   Throughput: 1 word/cycle while m_axis_data_tready=1; back-to-back frames with no
//   bubble between bin N-1 of frame k and bin 0 of frame k+1 if k+1 is FULL.
//   AXI rules: tdata/tlast held stable while tvalid && !tready; tvalid never drops
//   without a handshake; arbitrary tready patterns lose or duplicate no word
//   (output register plus 1-entry skid absorbs the RAM latency).
//   m_axis_data_tlast = 1 exactly on rcnt=N-1; read bank toggles on its handshake.
//  Simultaneous events: a bank released (DRAINING->EMPTY) on the same edge the write
//   side needs it is writable next cycle (tready rises 1 cycle after release).
//   Write to one bank and read from the other on the same cycle never conflict.
//  Both banks FULL/DRAINING: s_axis_data_tready=0 until one bank empties; the FFT
//   core stalls on its m_axis_data_tready.
// TESTING
//  T1 STAGE_NO=2, frame words k=0..15 data=k, tlast on 15, tready=1 -> output
//     0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15, tlast only on 15, no event pulses.
//  T2 STAGE_NO=2, three frames back-to-back, m_tready=1 -> 48 contiguous outputs,
//     each frame reordered as T1, first tvalid 2 cycles after input word 15.
//  T3 m_tready=0 while 3 frames offered -> 2 frames accepted, tready=0 after word 31;
//     raise m_tready -> frame 3 accepted after frame 1 drains; 48 correct outputs.
//  T4 random m_tready (50%) over 8 frames -> scoreboard vs digitrev model, data
//     stable under backpressure, zero drop/duplicate.
//  T5 tlast on word 7, none on 15 -> unexpected pulse after word 7, missing pulse
//     after word 15; frame still output as 16 reordered words.
//  T6 areset=1 for 1 cycle after 10 input words -> outputs 0, tready=1; next full
//     frame reorders correctly with no residue from the aborted one.

Source files
------------

// File: rtl/fft_digitrev_reorder.sv
// fft_digitrev_reorder: ping-pong reorder buffer behind a radix-4 FFT core.
// Frames arrive in base-4 digit-reversed order. They are written to a bank at
// the digit-reversed address, read back in natural order, and streamed out on an
// AXI-stream master. An output register plus a one-entry skid buffer absorb the
// one-cycle RAM read latency.
module fft_digitrev_reorder #(
  parameter int STAGE_NO = 5,
  parameter int DATA_W   = 16
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [DATA_W-1:0] s_axis_data_tdata,
  input  logic              s_axis_data_tvalid,
  output logic              s_axis_data_tready,
  input  logic              s_axis_data_tlast,
  output logic [DATA_W-1:0] m_axis_data_tdata,
  output logic              m_axis_data_tvalid,
  input  logic              m_axis_data_tready,
  output logic              m_axis_data_tlast,
  output logic              event_tlast_unexpected,
  output logic              event_tlast_missing
);
  localparam int AW    = 2 * STAGE_NO;
  localparam int DEPTH = 2 << AW;
  localparam logic [AW-1:0] LAST_IDX = {AW{1'b1}};
  localparam logic [AW-1:0] ZERO_IDX = {AW{1'b0}};
  localparam logic [AW-1:0] ONE_IDX  = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_t;

  // Reverse the order of the STAGE_NO base-4 digits of an index (an involution).
  function automatic logic [AW-1:0] digitrev4(input logic [AW-1:0] idx);
    logic [AW-1:0] rev;
    rev = ZERO_IDX;
    for (int i = 0; i < STAGE_NO; i++) begin
      rev[2*i +: 2] = idx[2*(STAGE_NO-1-i) +: 2];
    end
    return rev;
  endfunction

  logic [DATA_W-1:0] mem_r [0:DEPTH-1];

  bank_state_t       bank_st_r [2];
  bank_state_t       bank_nx_s [2];
  logic              wbank_r, wbank_nx_s;
  logic [AW-1:0]     wcnt_r;
  logic              ibank_r, rel_bank_r;
  logic [AW-1:0]     rcnt_r;
  logic              s_tready_r, s_tready_nx_s;
  logic              ev_unexp_r, ev_miss_r;
  logic [DATA_W-1:0] ram_data_r, out_data_r, skid_data_r;
  logic              ram_last_r, out_last_r, skid_last_r;
  logic              ram_vld_r, out_vld_r, skid_vld_r;
  logic              accept_s, wlast_s, pop_s, release_s, issue_s;
  logic [1:0]        occ_s;

  assign accept_s  = s_axis_data_tvalid && s_tready_r;
  assign wlast_s   = (wcnt_r == LAST_IDX);
  assign pop_s     = out_vld_r && m_axis_data_tready;
  assign release_s = pop_s && out_last_r;
  // Words already committed downstream of the RAM read port.
  assign occ_s     = {1'b0, out_vld_r} + {1'b0, skid_vld_r} + {1'b0, ram_vld_r};

  // Read issue: only when the read bank holds data and the output stage has room.
  always_comb begin
    issue_s = 1'b0;
    if ((bank_st_r[ibank_r] == BANK_FULL) ||
        ((bank_st_r[ibank_r] == BANK_DRAINING) && (rcnt_r != ZERO_IDX))) begin
      issue_s = ((occ_s - {1'b0, pop_s}) <= 2'd1);
    end else begin
      issue_s = 1'b0;
    end
  end

  // Per-bank state transitions; each bank sees at most one event per cycle.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_nx_s[b] = bank_st_r[b];
      if (accept_s && (wbank_r == b[0])) begin
        bank_nx_s[b] = wlast_s ? BANK_FULL : BANK_FILLING;
      end else if (issue_s && (ibank_r == b[0]) && (rcnt_r == ZERO_IDX)) begin
        bank_nx_s[b] = BANK_DRAINING;
      end else if (release_s && (rel_bank_r == b[0])) begin
        bank_nx_s[b] = BANK_EMPTY;
      end else begin
        bank_nx_s[b] = bank_st_r[b];
      end
    end
    wbank_nx_s    = wbank_r ^ (accept_s && wlast_s);
    s_tready_nx_s = (bank_nx_s[wbank_nx_s] == BANK_EMPTY) ||
                    (bank_nx_s[wbank_nx_s] == BANK_FILLING);
  end

  // Control registers: bank states, write/read counters, framing events.
  always_ff @(posedge aclk) begin
    if (areset) begin
      bank_st_r[0] <= BANK_EMPTY;
      bank_st_r[1] <= BANK_EMPTY;
      wbank_r      <= 1'b0;
      wcnt_r       <= ZERO_IDX;
      ibank_r      <= 1'b0;
      rcnt_r       <= ZERO_IDX;
      rel_bank_r   <= 1'b0;
      s_tready_r   <= 1'b1;
      ev_unexp_r   <= 1'b0;
      ev_miss_r    <= 1'b0;
      ram_vld_r    <= 1'b0;
      ram_last_r   <= 1'b0;
    end else begin
      bank_st_r[0] <= bank_nx_s[0];
      bank_st_r[1] <= bank_nx_s[1];
      wbank_r      <= wbank_nx_s;
      s_tready_r   <= s_tready_nx_s;
      ev_unexp_r   <= accept_s && s_axis_data_tlast && !wlast_s;
      ev_miss_r    <= accept_s && !s_axis_data_tlast && wlast_s;
      ram_vld_r    <= issue_s;
      if (accept_s) begin
        wcnt_r <= wcnt_r + ONE_IDX;
      end
      if (issue_s) begin
        rcnt_r     <= rcnt_r + ONE_IDX;
        ram_last_r <= (rcnt_r == LAST_IDX);
        if (rcnt_r == LAST_IDX) begin
          ibank_r <= ~ibank_r;
        end
      end
      if (release_s) begin
        rel_bank_r <= ~rel_bank_r;
      end
    end
  end

  // RAM write port: digit-reversed address within the current write bank.
  always_ff @(posedge aclk) begin
    if (accept_s) begin
      mem_r[{wbank_r, digitrev4(wcnt_r)}] <= s_axis_data_tdata;
    end
  end

  // RAM synchronous read port: natural address within the current read bank.
  always_ff @(posedge aclk) begin
    if (issue_s) begin
      ram_data_r <= mem_r[{ibank_r, rcnt_r}];
    end
  end

  // Output register with one-entry skid; RAM data always moves forward each cycle.
  always_ff @(posedge aclk) begin
    if (areset) begin
      out_data_r  <= {DATA_W{1'b0}};
      out_last_r  <= 1'b0;
      out_vld_r   <= 1'b0;
      skid_data_r <= {DATA_W{1'b0}};
      skid_last_r <= 1'b0;
      skid_vld_r  <= 1'b0;
    end else if (!out_vld_r || pop_s) begin
      if (skid_vld_r) begin
        out_data_r  <= skid_data_r;
        out_last_r  <= skid_last_r;
        out_vld_r   <= 1'b1;
        skid_data_r <= ram_data_r;
        skid_last_r <= ram_last_r;
        skid_vld_r  <= ram_vld_r;
      end else begin
        out_data_r  <= ram_data_r;
        out_last_r  <= ram_last_r;
        out_vld_r   <= ram_vld_r;
      end
    end else if (ram_vld_r) begin
      skid_data_r <= ram_data_r;
      skid_last_r <= ram_last_r;
      skid_vld_r  <= 1'b1;
    end
  end

  assign s_axis_data_tready     = s_tready_r;
  assign m_axis_data_tdata      = out_data_r;
  assign m_axis_data_tvalid     = out_vld_r;
  assign m_axis_data_tlast      = out_last_r;
  assign event_tlast_unexpected = ev_unexp_r;
  assign event_tlast_missing    = ev_miss_r;
endmodule

// File: tb/tb_fft_digitrev_reorder.sv
// tb_fft_digitrev_reorder: directed and randomized checks of the reorder stage
// (STAGE_NO=2, N=16) against a frame-level digit-reversal reference model.
module tb_fft_digitrev_reorder;
  localparam int SN = 2;
  localparam int N  = 16;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic [15:0] s_tdata = 16'd0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic [15:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        m_tlast;
  logic        ev_unexp, ev_miss;

  fft_digitrev_reorder #(.STAGE_NO(SN), .DATA_W(16)) dut (
    .aclk(clk), .areset(areset),
    .s_axis_data_tdata(s_tdata), .s_axis_data_tvalid(s_tvalid),
    .s_axis_data_tready(s_tready), .s_axis_data_tlast(s_tlast),
    .m_axis_data_tdata(m_tdata), .m_axis_data_tvalid(m_tvalid),
    .m_axis_data_tready(m_tready), .m_axis_data_tlast(m_tlast),
    .event_tlast_unexpected(ev_unexp), .event_tlast_missing(ev_miss)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc = 0;
  int rdy_mode = 1;          // 0: tready low, 1: tready high, 2: random
  bit rand_valid = 1'b0;
  int acc_cnt, n_unexp_seen, n_miss_seen, first_vld_step, first_done_step;
  bit pend_unexp = 1'b0, pend_miss = 1'b0;
  bit prev_vld = 1'b0, prev_rdy = 1'b0, prev_last = 1'b0;
  logic [15:0] prev_data = 16'd0;

  logic [15:0] src_d[$];
  logic        src_l[$];
  logic [15:0] in_frame[$];
  logic [15:0] exp_d[$];
  logic        exp_l[$];
  logic [15:0] out_log[$];
  int          hs_steps[$];

  logic [15:0] t1_tab [16] = '{16'd0, 16'd4, 16'd8, 16'd12, 16'd1, 16'd5, 16'd9, 16'd13,
                               16'd2, 16'd6, 16'd10, 16'd14, 16'd3, 16'd7, 16'd11, 16'd15};

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Base-4 digit reversal by plain arithmetic.
  function automatic int rev4(input int r);
    int v, o;
    v = r;
    o = 0;
    for (int k = 0; k < SN; k++) begin
      o = o * 4 + v % 4;
      v = v / 4;
    end
    return rev4_ret(o);
  endfunction

  function automatic int rev4_ret(input int o);
    return o;
  endfunction

  // Reference model: count-based framing, natural-order replay of complete frames.
  task automatic model_push(input logic [15:0] d, input logic last);
    int idx;
    idx = in_frame.size();
    if (last && idx != N - 1) pend_unexp = 1'b1;
    if (!last && idx == N - 1) pend_miss = 1'b1;
    in_frame.push_back(d);
    if (in_frame.size() == N) begin
      for (int r = 0; r < N; r++) begin
        exp_d.push_back(in_frame[rev4(r)]);
        exp_l.push_back(r == N - 1);
      end
      in_frame.delete();
      if (first_done_step < 0) first_done_step = cyc;
    end
  endtask

  task automatic add_word(input logic [15:0] d, input logic last);
    src_d.push_back(d);
    src_l.push_back(last);
  endtask

  task automatic new_test();
    acc_cnt = 0;
    n_unexp_seen = 0;
    n_miss_seen = 0;
    first_vld_step = -1;
    first_done_step = -1;
    out_log.delete();
    hs_steps.delete();
  endtask

  // One clock cycle: drive inputs at the falling edge, check outputs, update model.
  task automatic step();
    bit in_acc, out_hs;
    @(negedge clk);
    cyc++;
    if (src_d.size() != 0 && (!rand_valid || $urandom_range(0, 3) != 0)) begin
      s_tvalid = 1'b1;
      s_tdata  = src_d[0];
      s_tlast  = src_l[0];
    end else begin
      s_tvalid = 1'b0;
      s_tdata  = 16'd0;
      s_tlast  = 1'b0;
    end
    case (rdy_mode)
      0: m_tready = 1'b0;
      1: m_tready = 1'b1;
      default: m_tready = 1'($urandom_range(0, 1));
    endcase
    chk1("ev_unexpected", ev_unexp, pend_unexp);
    chk1("ev_missing", ev_miss, pend_miss);
    if (ev_unexp) n_unexp_seen++;
    if (ev_miss) n_miss_seen++;
    pend_unexp = 1'b0;
    pend_miss = 1'b0;
    if (prev_vld && !prev_rdy) begin
      chk1("hold_tvalid", m_tvalid, 1'b1);
      chkv("hold_tdata", m_tdata, prev_data);
      chk1("hold_tlast", m_tlast, prev_last);
    end
    if (m_tvalid && first_vld_step < 0) first_vld_step = cyc;
    out_hs = m_tvalid && m_tready;
    if (out_hs) begin
      chk1("output_expected", exp_d.size() != 0, 1'b1);
      if (exp_d.size() != 0) begin
        chkv("out_tdata", m_tdata, exp_d[0]);
        chk1("out_tlast", m_tlast, exp_l[0]);
        void'(exp_d.pop_front());
        void'(exp_l.pop_front());
      end
      out_log.push_back(m_tdata);
      hs_steps.push_back(cyc);
    end
    in_acc = s_tvalid && s_tready;
    if (in_acc) begin
      model_push(s_tdata, s_tlast);
      void'(src_d.pop_front());
      void'(src_l.pop_front());
      acc_cnt++;
    end
    prev_vld  = m_tvalid;
    prev_rdy  = m_tready;
    prev_data = m_tdata;
    prev_last = m_tlast;
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (src_d.size() == 0 && exp_d.size() == 0) break;
      step();
    end
    chkn({tag, "_pending_out"}, exp_d.size(), 0);
    chkn({tag, "_pending_in"}, src_d.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    areset = 1'b1;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    s_tdata = 16'd0;
    m_tready = 1'b0;
    @(negedge clk);
    areset = 1'b0;
    cyc += 2;
    src_d.delete();
    src_l.delete();
    in_frame.delete();
    exp_d.delete();
    exp_l.delete();
    pend_unexp = 1'b0;
    pend_miss = 1'b0;
    prev_vld = 1'b0;
    chk1("rst_s_tready", s_tready, 1'b1);
    chk1("rst_m_tvalid", m_tvalid, 1'b0);
    chk1("rst_m_tlast", m_tlast, 1'b0);
    chkv("rst_m_tdata", m_tdata, 16'd0);
    chk1("rst_ev_unexpected", ev_unexp, 1'b0);
    chk1("rst_ev_missing", ev_miss, 1'b0);
  endtask

  initial begin
    // Reset state
    new_test();
    do_reset();

    // T1: single ordered frame, natural-order output and latency
    new_test();
    rdy_mode = 1;
    for (int k = 0; k < N; k++) add_word(16'(k), k == N - 1);
    drain("t1", 200);
    chkn("t1_count", out_log.size(), N);
    for (int i = 0; i < N && i < out_log.size(); i++) chkv("t1_table", out_log[i], t1_tab[i]);
    chkn("t1_latency", first_vld_step, first_done_step + 3);
    chkn("t1_ev_unexp_count", n_unexp_seen, 0);
    chkn("t1_ev_miss_count", n_miss_seen, 0);

    // T2: three frames back-to-back, contiguous output across frames 1 and 2
    new_test();
    for (int f = 0; f < 3; f++)
      for (int k = 0; k < N; k++) add_word(16'(f * 256 + k), k == N - 1);
    drain("t2", 400);
    chkn("t2_count", out_log.size(), 3 * N);
    chkn("t2_latency", first_vld_step, first_done_step + 3);
    for (int i = 1; i < 2 * N && i < hs_steps.size(); i++)
      chkn("t2_contiguous", hs_steps[i], hs_steps[i-1] + 1);

    // T3: downstream blocked, only two frames fit
    new_test();
    rdy_mode = 0;
    for (int f = 0; f < 3; f++)
      for (int k = 0; k < N; k++) add_word(16'(16'h1000 + f * 16 + k), k == N - 1);
    for (int i = 0; i < 40; i++) step();
    chkn("t3_accepted_blocked", acc_cnt, 2 * N);
    chk1("t3_s_tready_low", s_tready, 1'b0);
    rdy_mode = 1;
    drain("t3", 400);
    chkn("t3_accepted_total", acc_cnt, 3 * N);
    chkn("t3_count", out_log.size(), 3 * N);

    // T4: random data, random valid and ready over 8 frames
    new_test();
    rdy_mode = 2;
    rand_valid = 1'b1;
    for (int f = 0; f < 8; f++)
      for (int k = 0; k < N; k++) add_word(16'($urandom_range(0, 65535)), k == N - 1);
    drain("t4", 3000);
    chkn("t4_count", out_log.size(), 8 * N);
    rand_valid = 1'b0;
    rdy_mode = 1;

    // T5: tlast misplaced on word 7 and missing on word 15
    new_test();
    for (int k = 0; k < N; k++) add_word(16'(16'h0500 + k), k == 7);
    drain("t5", 200);
    for (int i = 0; i < 3; i++) step();
    chkn("t5_ev_unexp_count", n_unexp_seen, 1);
    chkn("t5_ev_miss_count", n_miss_seen, 1);
    chkn("t5_count", out_log.size(), N);

    // T6: reset in the middle of a frame, then a clean frame
    new_test();
    for (int k = 0; k < 10; k++) add_word(16'(16'h0A00 + k), 1'b0);
    for (int i = 0; i < 50 && src_d.size() != 0; i++) step();
    chkn("t6_partial_accepted", acc_cnt, 10);
    do_reset();
    new_test();
    rdy_mode = 1;
    for (int k = 0; k < N; k++) add_word(16'($urandom_range(0, 65535)), k == N - 1);
    drain("t6", 200);
    chkn("t6_count", out_log.size(), N);
    chkn("t6_latency", first_vld_step, first_done_step + 3);
    for (int i = 0; i < 4; i++) step();
    chk1("t6_idle_tvalid", m_tvalid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
